// File: rtl/machine_timer.sv
// rtl/machine_timer.sv - memory-mapped RISC-V machine timer (mtime/mtimecmp) with prescaler
//
// Purpose:
//   Holds a 64-bit mtime counter that is advanced by a programmable prescaler,
//   and a 64-bit mtimecmp compare register. It drives a registered,
//   level-sensitive timer_interrupt while ie is set and mtime >= mtimecmp.
//   Registers are reached through a single-cycle req/ack port.
//
// Register map (byte offsets, addr[1:0] ignored):
//   0x00 mtime_lo     0x04 mtime_hi (returns hi_shadow)
//   0x08 mtimecmp_lo  0x0C mtimecmp_hi
//   0x10 ctrl         bit0 en, bit1 ie
//   0x14 prescale     low PRESCALE_W bits
//   0x18-0x1C         read 0, writes ignored
//
// Ports:
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   req             one-cycle access request
//   we              1 = write, 0 = read (sampled with req)
//   addr[4:0]       byte offset
//   wdata[31:0]     write data (sampled with req)
//   rdata[31:0]     read data, valid while ack = 1, 0 otherwise
//   ack             one-cycle completion, the cycle after req
//   timer_interrupt machine timer interrupt, level
module machine_timer #(
  parameter int          PRESCALE_W   = 16,
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        timer_interrupt
);

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;
  localparam logic [2:0] IDX_PRESCALE = 3'd5;

  logic [63:0]           r_mtime;
  logic [63:0]           r_mtimecmp;
  logic                  r_en;
  logic                  r_ie;
  logic [PRESCALE_W-1:0] r_prescale;
  logic [PRESCALE_W-1:0] r_pcnt;
  logic [31:0]           r_hi_shadow;
  logic [31:0]           r_rdata;
  logic                  r_ack;
  logic                  r_irq;

  logic [2:0]            w_idx;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_tick;
  logic                  w_cmp_hit;
  logic [31:0]           w_rd_data;
  logic [63:0]           w_mtime_next;
  logic [PRESCALE_W-1:0] w_pcnt_next;
  logic                  w_unused_addr;

  assign w_idx         = addr[4:2];
  assign w_wr          = req & we;
  assign w_rd          = req & ~we;
  assign w_unused_addr = &{1'b0, addr[1:0]};

  // A tick is the cycle in which the prescaler counter has reached its limit.
  assign w_tick    = r_en && (r_pcnt == r_prescale);
  assign w_cmp_hit = (r_mtime >= r_mtimecmp);

  // Read mux on current register values; mtime_hi comes from the shadow so a
  // lo-then-hi read pair is coherent across a carry.
  always_comb begin
    w_rd_data = 32'd0;
    case (w_idx)
      IDX_MTIME_LO: w_rd_data = r_mtime[31:0];
      IDX_MTIME_HI: w_rd_data = r_hi_shadow;
      IDX_CMP_LO:   w_rd_data = r_mtimecmp[31:0];
      IDX_CMP_HI:   w_rd_data = r_mtimecmp[63:32];
      IDX_CTRL:     w_rd_data = {30'd0, r_ie, r_en};
      IDX_PRESCALE: w_rd_data = 32'(r_prescale);
      default:      w_rd_data = 32'd0;
    endcase
  end

  // A bus write to either mtime half wins over a same-cycle tick: the
  // addressed half is replaced, the other keeps its pre-tick value, and the
  // tick is lost.
  always_comb begin
    w_mtime_next = r_mtime;
    if (w_wr && (w_idx == IDX_MTIME_LO)) begin
      w_mtime_next = {r_mtime[63:32], wdata};
    end else if (w_wr && (w_idx == IDX_MTIME_HI)) begin
      w_mtime_next = {wdata, r_mtime[31:0]};
    end else if (w_tick) begin
      w_mtime_next = r_mtime + 64'd1;
    end
  end

  // Writing prescale restarts the divide period from zero.
  always_comb begin
    w_pcnt_next = r_pcnt;
    if (w_wr && (w_idx == IDX_PRESCALE)) begin
      w_pcnt_next = '0;
    end else if (r_en) begin
      w_pcnt_next = w_tick ? '0 : r_pcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtime    <= 64'd0;
      r_pcnt     <= '0;
    end else begin
      r_mtime    <= w_mtime_next;
      r_pcnt     <= w_pcnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mtimecmp <= MTIMECMP_RST;
      r_en       <= 1'b0;
      r_ie       <= 1'b0;
      r_prescale <= '0;
    end else if (w_wr) begin
      case (w_idx)
        IDX_CMP_LO:   r_mtimecmp[31:0]  <= wdata;
        IDX_CMP_HI:   r_mtimecmp[63:32] <= wdata;
        IDX_CTRL: begin
          r_en <= wdata[0];
          r_ie <= wdata[1];
        end
        IDX_PRESCALE: r_prescale <= wdata[PRESCALE_W-1:0];
        default: ;
      endcase
    end
  end

  // Response path: ack one cycle after req, rdata only for reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ack       <= 1'b0;
      r_rdata     <= 32'd0;
      r_hi_shadow <= 32'd0;
    end else begin
      r_ack   <= req;
      r_rdata <= w_rd ? w_rd_data : 32'd0;
      if (w_rd && (w_idx == IDX_MTIME_LO)) begin
        r_hi_shadow <= r_mtime[63:32];
      end
    end
  end

  // Interrupt is registered from the registered compare operands, so a change
  // to mtime or mtimecmp shows up two cycles after the cycle that caused it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ie & w_cmp_hit;
    end
  end

  assign rdata           = r_rdata;
  assign ack             = r_ack;
  assign timer_interrupt = r_irq;

endmodule

// File: tb/tb_machine_timer.sv
// tb/tb_machine_timer.sv - scoreboard bench for machine_timer with a behavioural model
module tb_machine_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ack;
  logic        timer_interrupt;

  machine_timer dut (
    .clk             (clk),
    .rst             (rst),
    .req             (req),
    .we              (we),
    .addr            (addr),
    .wdata           (wdata),
    .rdata           (rdata),
    .ack             (ack),
    .timer_interrupt (timer_interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_en;
  logic        m_ie;
  logic [15:0] m_pre;
  logic [15:0] m_pcnt;
  logic [31:0] m_shadow;
  logic        m_ack;
  logic        m_irq;
  logic [31:0] exp_q[$];

  task automatic m_reset();
    m_mtime  = 64'd0;
    m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en     = 1'b0;
    m_ie     = 1'b0;
    m_pre    = 16'd0;
    m_pcnt   = 16'd0;
    m_shadow = 32'd0;
    m_ack    = 1'b0;
    m_irq    = 1'b0;
    exp_q.delete();
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a >> 2)
      5'd0:    return m_mtime[31:0];
      5'd1:    return m_shadow;
      5'd2:    return m_cmp[31:0];
      5'd3:    return m_cmp[63:32];
      5'd4:    return {30'd0, m_ie, m_en};
      5'd5:    return {16'd0, m_pre};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer as described by its rules.
  task automatic m_step();
    logic       tick;
    logic [4:0] w;
    w     = addr >> 2;
    m_ack = req;
    m_irq = m_ie && (m_mtime >= m_cmp);
    if (req) begin
      exp_q.push_back(we ? 32'd0 : m_read(addr));
      if (!we && w == 5'd0) m_shadow = m_mtime[63:32];
    end
    tick = m_en && (m_pcnt == m_pre);
    if (m_en) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
    if (req && we && w == 5'd0)      m_mtime[31:0]  = wdata;
    else if (req && we && w == 5'd1) m_mtime[63:32] = wdata;
    else if (tick)                   m_mtime        = m_mtime + 64'd1;
    if (req && we) begin
      case (w)
        5'd2: m_cmp[31:0]  = wdata;
        5'd3: m_cmp[63:32] = wdata;
        5'd4: begin m_en = wdata[0]; m_ie = wdata[1]; end
        5'd5: begin m_pre = wdata[15:0]; m_pcnt = 16'd0; end
        default: ;
      endcase
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) m_reset();
      else      m_step();
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        checks++;
        if (ack !== m_ack) begin
          failures++;
          $display("FAIL ack t=%0t got=%b want=%b", $time, ack, m_ack);
        end
        checks++;
        if (timer_interrupt !== m_irq) begin
          failures++;
          $display("FAIL irq t=%0t got=%b want=%b mtime=%h cmp=%h", $time,
                   timer_interrupt, m_irq, m_mtime, m_cmp);
        end
        if (ack === 1'b1) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL spurious_ack t=%0t got=ack want=no_ack", $time);
          end else begin
            e = exp_q.pop_front();
            if (rdata !== e) begin
              failures++;
              $display("FAIL rdata t=%0t got=%h want=%h", $time, rdata, e);
            end
          end
        end else if (m_ack && exp_q.size() > 0) begin
          e = exp_q.pop_front();
        end
      end
    end
  end

  task automatic access(input logic w, input logic [4:0] a, input logic [31:0] d);
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
    req   = 1'b0;
    we    = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    access(1'b1, a, d);
  endtask

  task automatic rd(input logic [4:0] a);
    access(1'b0, a, $urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] gen_data(input logic [2:0] idx);
    case (idx)
      3'd0: return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
      3'd1: return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 2);
      3'd2: return m_mtime[31:0] + $urandom_range(0, 40);
      3'd3: return m_mtime[63:32] + $urandom_range(0, 1);
      3'd4: return ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 32'd3;
      3'd5: return ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] idx;
    idle(3);
    rst = 1'b1;
    idle(1);

    // Reset values and readback
    rd(5'h08);
    rd(5'h0C);
    rd(5'h00);
    rd(5'h04);
    rd(5'h10);
    rd(5'h14);
    idle(2);

    // Prescaled count, then hold with en cleared
    wr(5'h14, 32'd3);
    wr(5'h10, 32'd1);
    idle(40);
    rd(5'h00);
    wr(5'h10, 32'd0);
    idle(20);
    rd(5'h00);

    // Interrupt assert/clear and ie gating
    wr(5'h14, 32'd0);
    wr(5'h00, 32'd0);
    wr(5'h04, 32'd0);
    wr(5'h0C, 32'hFFFF_FFFF);
    wr(5'h08, 32'd20);
    wr(5'h0C, 32'd0);
    wr(5'h10, 32'd3);
    idle(30);
    wr(5'h08, 32'd1000);
    idle(5);
    wr(5'h10, 32'd1);
    wr(5'h08, 32'd0);
    idle(10);

    // Wrap to zero
    wr(5'h10, 32'd0);
    wr(5'h04, 32'hFFFF_FFFF);
    wr(5'h00, 32'hFFFF_FFFE);
    wr(5'h10, 32'd1);
    idle(3);
    rd(5'h00);
    rd(5'h04);

    // Lo/hi read straddling a carry into hi
    wr(5'h10, 32'd0);
    wr(5'h04, 32'd0);
    wr(5'h00, 32'hFFFF_FFFD);
    wr(5'h10, 32'd1);
    idle(1);
    rd(5'h00);
    idle(1);
    rd(5'h04);
    rd(5'h00);
    rd(5'h04);

    // Write to mtime_lo colliding with a tick that would carry into hi
    wr(5'h10, 32'd0);
    wr(5'h04, 32'd5);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h10, 32'd1);
    wr(5'h00, 32'h55);
    rd(5'h00);
    rd(5'h04);
    wr(5'h10, 32'd0);
    rd(5'h00);
    rd(5'h04);

    // Unmapped offsets
    wr(5'h18, 32'hDEAD_BEEF);
    rd(5'h18);
    rd(5'h1C);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle($urandom_range(1, 4));
      end else begin
        idx = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 0) rd({idx, 2'($urandom_range(0, 3))});
        else                           wr({idx, 2'b00}, gen_data(idx));
      end
    end

    // Reset in the cycle after a request, with the interrupt active
    wr(5'h0C, 32'd0);
    wr(5'h08, 32'd0);
    wr(5'h14, 32'd2);
    wr(5'h10, 32'd3);
    idle(4);
    rd(5'h10);
    #1 rst = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack got=%b want=0", ack);
    end
    checks++;
    if (timer_interrupt !== 1'b0) begin
      failures++;
      $display("FAIL reset_irq got=%b want=0", timer_interrupt);
    end
    checks++;
    if (rdata !== 32'd0) begin
      failures++;
      $display("FAIL reset_rdata got=%h want=0", rdata);
    end
    idle(3);
    rst = 1'b1;
    idle(2);
    rd(5'h00);
    rd(5'h04);
    rd(5'h08);
    rd(5'h0C);
    rd(5'h10);
    rd(5'h14);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
